// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter for a 64-bit Avalon-style memory port with ordered read-return steering
module mem_bus_arbiter #(
  parameter int PENDING_DEPTH = 4,
  parameter int TAG_AW = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [25:0] i_m0_address,
  input  logic [7:0]  i_m0_be,
  input  logic        i_m0_read_req,
  input  logic        i_m0_write_req,
  input  logic [7:0]  i_m0_burst_count,
  input  logic        i_m0_burst_begin,
  input  logic [63:0] i_m0_write_data,
  output logic [63:0] o_m0_read_data,
  output logic        o_m0_read_data_valid,
  output logic        o_m0_wait_request,
  input  logic [25:0] i_m1_address,
  input  logic [7:0]  i_m1_be,
  input  logic        i_m1_read_req,
  input  logic        i_m1_write_req,
  input  logic [7:0]  i_m1_burst_count,
  input  logic        i_m1_burst_begin,
  input  logic [63:0] i_m1_write_data,
  output logic [63:0] o_m1_read_data,
  output logic        o_m1_read_data_valid,
  output logic        o_m1_wait_request,
  output logic [25:0] o_mem_address,
  output logic [7:0]  o_mem_be,
  output logic [7:0]  o_mem_burst_count,
  output logic [63:0] o_mem_write_data,
  output logic        o_mem_read_req,
  output logic        o_mem_write_req,
  output logic        o_mem_burst_begin,
  input  logic [63:0] i_mem_read_data,
  input  logic        i_mem_read_data_valid,
  input  logic        i_mem_wait_request,
  output logic        o_orphan_err
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic owner, last_grant;
  logic [7:0] wlen, beats, rcnt;
  logic [TAG_AW:0] count;
  logic [TAG_AW-1:0] wr_ptr, rd_ptr;
  logic tag_id [PENDING_DEPTH];
  logic [7:0] tag_len [PENDING_DEPTH];
  logic req0, req1, grant, own_rd, own_wr, own_bb, full, empty, rd_block;
  logic [7:0] own_bc, own_len;
  logic first, rd_acc, wr_acc, wr_done, drop, push, ret, pop;
  assign req0 = i_m0_read_req | i_m0_write_req;
  assign req1 = i_m1_read_req | i_m1_write_req;
  assign grant = state == GRANT;
  assign own_rd = owner ? i_m1_read_req : i_m0_read_req;
  assign own_wr = owner ? i_m1_write_req : i_m0_write_req;
  assign own_bb = owner ? i_m1_burst_begin : i_m0_burst_begin;
  assign own_bc = owner ? i_m1_burst_count : i_m0_burst_count;
  assign own_len = own_bc == 8'd0 ? 8'd1 : own_bc;
  assign full = count == (TAG_AW+1)'(PENDING_DEPTH);
  assign empty = count == '0;
  assign rd_block = own_rd & full;
  assign first = beats == 8'd0;
  assign rd_acc = o_mem_read_req & !i_mem_wait_request;
  assign wr_acc = o_mem_write_req & !i_mem_wait_request;
  assign wr_done = wr_acc & (beats + 8'd1 == (first ? own_len : wlen));
  assign drop = !own_rd & !own_wr & first;
  assign push = rd_acc;
  assign ret = i_mem_read_data_valid & !empty;
  assign pop = ret & (rcnt + 8'd1 == tag_len[rd_ptr]);
  // Command state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  // Next state: arbitrate from IDLE, release the grant when the command completes or is withdrawn
  always_comb begin
    state_nxt = state == IDLE ? (req0 | req1 ? GRANT : IDLE) : (rd_acc | wr_done | drop ? IDLE : GRANT);
  end
  // Memory-side mux and per-master handshakes driven from the grant state
  always_comb begin
    o_mem_address = grant ? (owner ? i_m1_address : i_m0_address) : '0;
    o_mem_be = grant ? (owner ? i_m1_be : i_m0_be) : '0;
    o_mem_burst_count = grant ? own_bc : '0;
    o_mem_write_data = grant ? (owner ? i_m1_write_data : i_m0_write_data) : '0;
    o_mem_read_req = grant & own_rd & !rd_block;
    o_mem_write_req = grant & own_wr;
    o_mem_burst_begin = grant & own_bb;
    o_m0_wait_request = !(grant & !owner) | i_mem_wait_request | rd_block;
    o_m1_wait_request = !(grant & owner) | i_mem_wait_request | rd_block;
    o_m0_read_data = i_mem_read_data;
    o_m1_read_data = i_mem_read_data;
    o_m0_read_data_valid = ret & !tag_id[rd_ptr];
    o_m1_read_data_valid = ret & tag_id[rd_ptr];
  end
  // Ownership, round-robin history and write-burst beat tracking
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      owner <= 1'b0;
      last_grant <= 1'b1;
      beats <= '0;
      wlen <= '0;
    end else begin
      if (state == IDLE && (req0 | req1)) owner <= req0 & req1 ? !last_grant : req1;
      if (rd_acc | wr_done) last_grant <= owner;
      beats <= wr_done ? 8'd0 : wr_acc ? beats + 8'd1 : beats;
      if (wr_acc & first) wlen <= own_len;
    end
  // Tag FIFO pointers, occupancy, return beat counter and orphan flag
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rcnt <= '0;
      o_orphan_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + TAG_AW'(push);
      rd_ptr <= rd_ptr + TAG_AW'(pop);
      count <= count + (TAG_AW+1)'(push) - (TAG_AW+1)'(pop);
      rcnt <= pop ? 8'd0 : ret ? rcnt + 8'd1 : rcnt;
      o_orphan_err <= o_orphan_err | (i_mem_read_data_valid & empty);
    end
  // Tag FIFO storage: issuing master and effective burst length
  always_ff @(posedge i_clk)
    if (push) begin
      tag_id[wr_ptr] <= owner;
      tag_len[wr_ptr] <= own_len;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: table-driven arbitration vectors plus scoreboarded read-return sequences
module tb_mem_bus_arbiter;
  localparam logic [25:0] A0 = 26'h00000aa;
  localparam logic [25:0] A1 = 26'h0000155;
  localparam logic [63:0] D0 = 64'h0000_0000_aaaa_0000;
  localparam logic [63:0] D1 = 64'h0000_0000_bbbb_0000;
  typedef struct {
    logic r0;
    logic r1;
    logic exp_id;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [25:0] m0_address, m1_address, mem_address;
  logic [7:0] m0_be, m1_be, m0_bc, m1_bc, mem_be, mem_bc;
  logic m0_rd, m0_wr, m0_bb, m1_rd, m1_wr, m1_bb;
  logic [63:0] m0_wd, m1_wd, m0_rdata, m1_rdata, mem_wd, mem_rdata;
  logic m0_rvalid, m1_rvalid, m0_wait, m1_wait;
  logic mem_rd, mem_wr, mem_bb, mem_rvalid, mem_wait, orphan;
  int checks = 0, errors = 0;
  int exp_q[$];
  vec_t vecs[8];
  mem_bus_arbiter #(.PENDING_DEPTH(4), .TAG_AW(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_address(m0_address), .i_m0_be(m0_be), .i_m0_read_req(m0_rd), .i_m0_write_req(m0_wr),
    .i_m0_burst_count(m0_bc), .i_m0_burst_begin(m0_bb), .i_m0_write_data(m0_wd),
    .o_m0_read_data(m0_rdata), .o_m0_read_data_valid(m0_rvalid), .o_m0_wait_request(m0_wait),
    .i_m1_address(m1_address), .i_m1_be(m1_be), .i_m1_read_req(m1_rd), .i_m1_write_req(m1_wr),
    .i_m1_burst_count(m1_bc), .i_m1_burst_begin(m1_bb), .i_m1_write_data(m1_wd),
    .o_m1_read_data(m1_rdata), .o_m1_read_data_valid(m1_rvalid), .o_m1_wait_request(m1_wait),
    .o_mem_address(mem_address), .o_mem_be(mem_be), .o_mem_burst_count(mem_bc), .o_mem_write_data(mem_wd),
    .o_mem_read_req(mem_rd), .o_mem_write_req(mem_wr), .o_mem_burst_begin(mem_bb),
    .i_mem_read_data(mem_rdata), .i_mem_read_data_valid(mem_rvalid), .i_mem_wait_request(mem_wait),
    .o_orphan_err(orphan)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    m0_address = A0; m1_address = A1; m0_be = 8'h0f; m1_be = 8'hf0;
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    m0_bc = 8'd1; m1_bc = 8'd1; m0_bb = 1; m1_bb = 1;
    m0_wd = D0; m1_wd = D1;
    mem_rdata = '0; mem_rvalid = 0; mem_wait = 0;
  endtask
  task automatic return_beats(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1;
      mem_rdata = base + 64'(i);
      tick();
    end
    mem_rvalid = 0;
  endtask
  // Scoreboard: every memory read beat consumes one expected routing entry (-1 means no owner)
  always @(negedge clk)
    if (rst_n && mem_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got a read beat expected none");
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("rvalid_m0", m0_rvalid, e == 0);
        chk("rvalid_m1", m1_rvalid, e == 1);
        chk("rdata_m0", m0_rdata, mem_rdata);
        chk("rdata_m1", m1_rdata, mem_rdata);
      end
    end
  initial begin
    int acc, cyc;
    vecs[0] = '{1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0};
    clear_inputs();
    m0_wr = 1; m1_wr = 1;
    tick();
    tick();
    chk("rst_wait_m0", m0_wait, 1);
    chk("rst_wait_m1", m1_wait, 1);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_address, 0);
    chk("rst_orphan", orphan, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    rst_n = 1;
    // Round-robin single-beat writes
    foreach (vecs[k]) begin
      m0_wr = vecs[k].r0; m1_wr = vecs[k].r1;
      #1;
      chk("idle_wait_m0", m0_wait, 1);
      chk("idle_wait_m1", m1_wait, 1);
      chk("idle_mem_wr", mem_wr, 0);
      tick();
      chk("rr_addr", mem_address, vecs[k].exp_id ? A1 : A0);
      chk("rr_data", mem_wd, vecs[k].exp_id ? D1 : D0);
      chk("rr_mem_wr", mem_wr, 1);
      chk("rr_wait_m0", m0_wait, vecs[k].exp_id);
      chk("rr_wait_m1", m1_wait, !vecs[k].exp_id);
      tick();
    end
    clear_inputs();
    // m0 read burst 4
    m0_rd = 1; m0_bc = 8'd4; m0_address = 26'h100;
    tick();
    chk("rd4_wait_m0", m0_wait, 0);
    chk("rd4_mem_rd", mem_rd, 1);
    chk("rd4_addr", mem_address, 26'h100);
    chk("rd4_bc", mem_bc, 4);
    repeat (4) exp_q.push_back(0);
    tick();
    chk("rd4_mem_rd_once", mem_rd, 0);
    chk("rd4_wait_after", m0_wait, 1);
    clear_inputs();
    tick();
    tick();
    return_beats(4, 64'h1000);
    tick();
    chk("rd4_q_empty", exp_q.size(), 0);
    // m1 write burst 8 under toggling memory stall while m0 also requests
    m0_wr = 1;
    m1_wr = 1; m1_bc = 8'd8;
    tick();
    acc = 0;
    cyc = 0;
    while (acc < 8 && cyc < 64) begin
      mem_wait = cyc[0];
      m1_bb = acc == 0;
      m1_wd = D1 + 64'(acc);
      #1;
      chk("wb_wait_m0", m0_wait, 1);
      chk("wb_burst_begin", mem_bb, acc == 0);
      chk("wb_data", mem_wd, D1 + 64'(acc));
      chk("wb_wait_m1", m1_wait, mem_wait);
      if (!m1_wait) acc++;
      cyc++;
      tick();
    end
    chk("wb_beats", acc, 8);
    mem_wait = 0;
    #1;
    chk("wb_end_wait_m1", m1_wait, 1);
    chk("wb_end_wait_m0", m0_wait, 1);
    chk("wb_end_mem_wr", mem_wr, 0);
    m1_wr = 0;
    tick();
    chk("wb_next_wait_m0", m0_wait, 0);
    chk("wb_next_addr", mem_address, A0);
    tick();
    clear_inputs();
    // Five single-beat reads against a 4-deep tag FIFO
    m0_rd = 1; m0_address = 26'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("f_mem_rd", mem_rd, 1);
      chk("f_wait_m0", m0_wait, 0);
      exp_q.push_back(0);
      tick();
    end
    tick();
    chk("full_wait_m0", m0_wait, 1);
    chk("full_mem_rd", mem_rd, 0);
    tick();
    chk("full_wait_m0_b", m0_wait, 1);
    mem_rvalid = 1; mem_rdata = 64'h2000;
    #1;
    chk("full_pop_cycle_wait", m0_wait, 1);
    chk("full_pop_cycle_rd", mem_rd, 0);
    tick();
    mem_rvalid = 0;
    #1;
    chk("unblock_wait_m0", m0_wait, 0);
    chk("unblock_mem_rd", mem_rd, 1);
    exp_q.push_back(0);
    tick();
    m0_rd = 0;
    return_beats(4, 64'h2100);
    tick();
    chk("full_q_empty", exp_q.size(), 0);
    // Interleaved m0 burst 2 and m1 burst 3, then a stray beat
    m0_rd = 1; m0_bc = 8'd2; m0_address = 26'h300;
    tick();
    chk("il_wait_m0", m0_wait, 0);
    repeat (2) exp_q.push_back(0);
    tick();
    m0_rd = 0;
    m1_rd = 1; m1_bc = 8'd3;
    tick();
    chk("il_wait_m1", m1_wait, 0);
    chk("il_bc", mem_bc, 3);
    repeat (3) exp_q.push_back(1);
    tick();
    m1_rd = 0;
    return_beats(5, 64'h3000);
    tick();
    chk("il_q_empty", exp_q.size(), 0);
    chk("il_orphan_clear", orphan, 0);
    exp_q.push_back(-1);
    return_beats(1, 64'h3100);
    #1;
    chk("orphan_set", orphan, 1);
    tick();
    chk("orphan_sticky", orphan, 1);
    // Asynchronous reset in the middle of an m0 write burst, with an m1 read left pending
    m0_wr = 1;
    tick();
    tick();
    m0_wr = 0;
    m1_rd = 1;
    tick();
    tick();
    m1_rd = 0;
    m0_wr = 1; m0_bc = 8'd4;
    tick();
    m0_bb = 0;
    tick();
    tick();
    chk("mid_burst_mem_wr", mem_wr, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_mem_wr", mem_wr, 0);
    chk("arst_mem_bb", mem_bb, 0);
    chk("arst_mem_addr", mem_address, 0);
    chk("arst_mem_bc", mem_bc, 0);
    chk("arst_wait", {m0_wait, m1_wait}, 2'b11);
    chk("arst_orphan", orphan, 0);
    clear_inputs();
    tick();
    rst_n = 1;
    m0_wr = 1; m1_wr = 1;
    tick();
    chk("post_rst_wait_m0", m0_wait, 0);
    chk("post_rst_wait_m1", m1_wait, 1);
    chk("post_rst_addr", mem_address, A0);
    tick();
    chk("post_rst_single_done", m0_wait, 1);
    clear_inputs();
    exp_q.push_back(-1);
    return_beats(1, 64'h4000);
    #1;
    chk("post_rst_fifo_empty", orphan, 1);
    tick();
    chk("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
